// File: rtl/board_pkg.sv
// Playboard types and default colours shared by draw_board and its cursor.
package board_pkg;
  localparam int CELL_IDX_W = 4;

  typedef logic [CELL_IDX_W-1:0] cell_idx_t;

  // One-cycle step pulses; up/down act on rows, left/right on columns.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } move_t;

  localparam logic [11:0] DEF_LINE_RGB   = 12'hfff;
  localparam logic [11:0] DEF_CURSOR_RGB = 12'hf00;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600 @ 60 Hz) and counter widths.
package vga_pkg;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W    = 12;

  localparam int H_ACTIVE = 800;
  localparam int H_FRONT  = 40;
  localparam int H_SYNC   = 128;
  localparam int H_TOTAL  = 1056;
  localparam int V_ACTIVE = 600;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 4;
  localparam int V_TOTAL  = 628;
endpackage

// File: rtl/vga_if.sv
// Pixel-chain bus between VGA stages.
// Stream contract: no handshake; one pixel per clk, every field valid each
// cycle, and downstream must always accept (there is no ready/backpressure).
interface vga_if;
  logic [vga_pkg::HCOUNT_W-1:0] hcount;
  logic [vga_pkg::VCOUNT_W-1:0] vcount;
  logic                         hsync;
  logic                         vsync;
  logic                         hblnk;
  logic                         vblnk;
  logic [vga_pkg::RGB_W-1:0]    rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/board_cursor.sv
// Cursor position, frame-synchronous display copy and optional blink phase.
// Optional feature: DRAW_BOARD_BLINK_EN enables the blink frame counter.
module board_cursor
  import board_pkg::*;
#(
  parameter int CELLS        = 12,
  parameter int BLINK_FRAMES = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  move_t     move,
  input  logic      vblnk,
  output cell_idx_t cur_x,
  output cell_idx_t cur_y,
  output cell_idx_t disp_x,
  output cell_idx_t disp_y,
  output logic      visible
);
  localparam cell_idx_t MAX_IDX = cell_idx_t'(CELLS - 1);

  logic vblnk_q;
  logic frame_start;

  assign frame_start = vblnk & ~vblnk_q;

  // Saturating single step; opposing pulses on one axis cancel.
  function automatic cell_idx_t step(cell_idx_t v, logic dec, logic inc);
    if (inc && !dec && v != MAX_IDX) return v + 1'b1;
    if (dec && !inc && v != '0) return v - 1'b1;
    return v;
  endfunction

  // Cursor registers, updated one clk after the move pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      cur_x <= step(cur_x, move.left, move.right);
      cur_y <= step(cur_y, move.up, move.down);
    end
  end

  // Display copy loads at vblnk rise with the pre-move cursor, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      disp_x  <= '0;
      disp_y  <= '0;
    end else begin
      vblnk_q <= vblnk;
      if (frame_start) begin
        disp_x <= cur_x;
        disp_y <= cur_y;
      end
    end
  end

`ifdef DRAW_BOARD_BLINK_EN
  localparam int FC_W = ($clog2(BLINK_FRAMES) > 0) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;

  // Frame counter 0..BLINK_FRAMES-1; each wrap flips the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  // No blink logic: cursor always shown (a zero blink period means never shown).
  assign visible = (BLINK_FRAMES != 0);
`endif
endmodule

// File: rtl/draw_board.sv
// Grid overlay with a movable cursor cell; one clk of latency in the vga_if chain.
// Optional feature: DRAW_BOARD_BLINK_EN makes the cursor blink (see board_cursor).
module draw_board
  import board_pkg::*;
#(
  parameter int          X_POS        = 0,
  parameter int          Y_POS        = 0,
  parameter int          CELLS        = 12,
  parameter int          CELL_PX      = 32,
  parameter int          LINE_W       = 2,
  parameter logic [11:0] LINE_RGB     = DEF_LINE_RGB,
  parameter logic [11:0] CURSOR_RGB   = DEF_CURSOR_RGB,
  parameter int          BLINK_FRAMES = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  vga_if.in         in,
  vga_if.out        out,
  input  move_t     move,
  output cell_idx_t cur_x,
  output cell_idx_t cur_y
);
  localparam int BOARD_PX = CELLS * CELL_PX + LINE_W;
  localparam int PX_W     = ($clog2(CELL_PX) > 0) ? $clog2(CELL_PX) : 1;

  localparam logic [10:0]     X_LO      = 11'(X_POS);
  localparam logic [10:0]     Y_LO      = 11'(Y_POS);
  localparam logic [10:0]     X_HI      = 11'(X_POS + BOARD_PX - 1);
  localparam logic [10:0]     SPAN      = 11'(BOARD_PX);
  localparam logic [PX_W-1:0] PX_LAST   = PX_W'(CELL_PX - 1);
  localparam logic [PX_W-1:0] PX_LW     = PX_W'(LINE_W);
  localparam cell_idx_t       CELL_EDGE = cell_idx_t'(CELLS);

  logic [PX_W-1:0] h_px, v_px;
  cell_idx_t       h_cell, v_cell;
  cell_idx_t       disp_x, disp_y;
  logic            visible;
  logic            h_in, v_in, line_end;
  logic            is_line, is_cursor;
  logic [11:0]     rgb_nxt;

  // Unsigned wrap makes a single compare cover both span bounds.
  assign h_in     = (in.hcount - X_LO) < SPAN;
  assign v_in     = (in.vcount - Y_LO) < SPAN;
  assign line_end = (in.hcount == X_HI) && v_in;

  board_cursor #(
    .CELLS        (CELLS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .move    (move),
    .vblnk   (in.vblnk),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .disp_x  (disp_x),
    .disp_y  (disp_y),
    .visible (visible)
  );

  // Horizontal scan tracker: pixel within cell, then cell index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_px   <= '0;
      h_cell <= '0;
    end else if (in.hblnk) begin
      h_px   <= '0;
      h_cell <= '0;
    end else if (h_in) begin
      if (h_px == PX_LAST) begin
        h_px   <= '0;
        h_cell <= h_cell + 1'b1;
      end else begin
        h_px <= h_px + 1'b1;
      end
    end
  end

  // Vertical scan tracker: advances on the last board pixel of each board line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_px   <= '0;
      v_cell <= '0;
    end else if (in.vblnk) begin
      v_px   <= '0;
      v_cell <= '0;
    end else if (line_end) begin
      if (v_px == PX_LAST) begin
        v_px   <= '0;
        v_cell <= v_cell + 1'b1;
      end else begin
        v_px <= v_px + 1'b1;
      end
    end
  end

  // Pixel classifier: blanking, then grid lines, then cursor, else pass-through.
  always_comb begin
    is_line   = (h_px < PX_LW) || (v_px < PX_LW) ||
                (h_cell == CELL_EDGE) || (v_cell == CELL_EDGE);
    is_cursor = !is_line && (h_cell == disp_x) && (v_cell == disp_y) && visible;
    rgb_nxt   = in.rgb;
    if (in.hblnk || in.vblnk) begin
      rgb_nxt = 12'h000;
    end else if (h_in && v_in) begin
      if (is_line) rgb_nxt = LINE_RGB;
      else if (is_cursor) rgb_nxt = CURSOR_RGB;
    end
  end

  // Output register: timing copied, rgb replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= rgb_nxt;
    end
  end
endmodule
